serv_shbuf: RTL and testbench
=============================

// Module: serv_shbuf
// PURPOSE
// Parametrised successor of the operand-B/data buffer in the serial core. Holds
// the W-bit data word for store alignment, load capture and shift operands, with
// a dedicated shift down-counter and FSM in place of reusing the data LSBs. The
// data word therefore survives shifts intact. Supports W=32 (RV32) or 64 (RV64)
// and right-shift remainder handling for any BITS_PER_CYCLE.
// PARAMETERS
// W               32                   data width, 32 or 64
// BITS_PER_CYCLE  1                    serial datapath width: 1, 2, 4 or 8
// SHW             $clog2(W)            shift-amount width (5 or 6)
// PORTS
// i_clk           in   1     clock
// i_rst           in   1     reset, asynchronous, active-high
// i_en            in   1     serial step enable
// i_init          in   1     init phase (operand shift-in)
// i_cnt_done      in   1     last step of current phase
// i_lsb           in   2     byte-lane offset for o_q
// i_byte_valid    in   1     current step carries valid data
// i_shift_op      in   1     shift instruction active
// i_right_shift_op in  1     shift is SRL/SRA
// i_op_b_sel      in   1     1: rs2, 0: imm
// i_rs2           in   B     rs2 serial slice (B=BITS_PER_CYCLE)
// i_imm           in   B     immediate serial slice
// o_op_b          out  B     selected operand B slice
// o_q             out  B     data slice at byte lane i_lsb
// o_sh_done       out  1     shift completes this cycle (combinational)
// o_sh_done_r     out  1     o_sh_done registered
// o_rem           out  LB+1  shamt mod B (LB=$clog2(B)), valid in COUNT
// o_rem_valid     out  1     remainder step active this cycle
// o_dat           out  W     full data word to bus
// i_load          in   1     bus ack: capture i_dat
// i_dat           in   W     bus read data
// BEHAVIOUR
// - Reset: dat=0, cnt=0, state=IDLE, o_sh_done_r=0, o_rem_valid=0; o_q=0.
// - o_op_b = i_op_b_sel ? i_rs2 : i_imm (combinational, no latency).
// - Data shift: when (i_en & i_byte_valid) | state==FILL&i_en, dat <=
//   {o_op_b, dat[W-1:B]}. i_load has priority: dat <= i_dat, any state.
// - o_q = dat[8*i_lsb +: B]; o_dat = dat.
// - FSM IDLE->FILL: i_init & i_shift_op & i_en. FILL->COUNT: i_cnt_done & i_en;
//   same edge loads cnt <= {1'b0, shamt}, shamt = next-dat[SHW-1:0].
//   COUNT->DONE: o_sh_done. DONE->IDLE: !i_shift_op. Any state->IDLE: !i_shift_op
//   & !i_init (aborted instruction); cnt cleared.
// - COUNT: first cycle, if i_right_shift_op & B>1 & o_rem!=0: o_rem_valid=1, cnt
//   held. Otherwise cnt <= cnt - B every clock (not gated by i_en).
// - o_sh_done = state==COUNT & !o_rem_valid & (cnt-B)[SHW]; o_sh_done_r <= it.
// - Width rule: cnt is SHW+1 bits; wrap into bit SHW marks completion, so
//   shamt=0 finishes in first COUNT cycle, shamt=W-1 after ceil(W/B) cycles.
// - o_rem = shamt[LB-1:0] (0 when B=1); held constant during COUNT/DONE.
// - i_load during COUNT: dat updated, cnt/state unaffected.
// - Reset mid-operation: immediate return to reset values, no partial update.
// TESTING
// - Reset asserted mid-COUNT -> state IDLE, cnt 0, o_sh_done_r 0 same cycle.
// - B=1, SLL shamt 5 -> o_sh_done high exactly 6th COUNT cycle, o_sh_done_r next.
// - B=4, SRL shamt 7 -> o_rem=3, one o_rem_valid cycle, then done after 2 steps.
// - B=2, shamt 0 -> o_sh_done on first COUNT cycle; dat unchanged through shift.
// - i_load i_dat=32'hA1B2C3D4, B=8, i_lsb=2 -> o_q=8'hB2; i_lsb=0 -> 8'hD4.
// - W=64 store: 32 steps rs2 slices (B=2) -> o_dat equals rs2 in upper 64 bits.

Source files
------------

// File: rtl/serv_shbuf.sv
// Operand-B / data word buffer for the serial core: holds the W-bit data word for
// stores, loads and shifts, with its own shift-amount counter so the word survives a shift.
module serv_shbuf #(
    parameter int W              = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SHW            = $clog2(W)
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_en,
    input  logic                               i_init,
    input  logic                               i_cnt_done,
    input  logic [1:0]                         i_lsb,
    input  logic                               i_byte_valid,
    input  logic                               i_shift_op,
    input  logic                               i_right_shift_op,
    input  logic                               i_op_b_sel,
    input  logic [BITS_PER_CYCLE-1:0]          i_rs2,
    input  logic [BITS_PER_CYCLE-1:0]          i_imm,
    output logic [BITS_PER_CYCLE-1:0]          o_op_b,
    output logic [BITS_PER_CYCLE-1:0]          o_q,
    output logic                               o_sh_done,
    output logic                               o_sh_done_r,
    output logic [$clog2(BITS_PER_CYCLE):0]    o_rem,
    output logic                               o_rem_valid,
    output logic [W-1:0]                       o_dat,
    input  logic                               i_load,
    input  logic [W-1:0]                       i_dat
);

    localparam int B  = BITS_PER_CYCLE;
    localparam int LB = $clog2(B);
    localparam logic [SHW:0] B_CNT = (SHW+1)'(B);
    localparam bit HAS_REM = (B > 1);

    typedef enum logic [1:0] {IDLE, FILL, COUNT, DONE} state_t;

    state_t          state;
    logic [W-1:0]    dat;
    logic [W-1:0]    dat_nxt;
    logic [SHW:0]    cnt;
    logic [SHW:0]    cnt_dec;
    logic            first_r;

    assign o_op_b = i_op_b_sel ? i_rs2 : i_imm;
    assign o_q    = dat[{i_lsb, 3'b000} +: B];
    assign o_dat  = dat;

    // Bus load wins over serial shift-in in every state
    always_comb begin
        dat_nxt = dat;
        if (i_load)
            dat_nxt = i_dat;
        else if ((i_en & i_byte_valid) | ((state == FILL) & i_en))
            dat_nxt = {o_op_b, dat[W-1:B]};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            dat <= '0;
        else
            dat <= dat_nxt;
    end

    // cnt steps by B, so its low LB bits stay equal to shamt mod B for the whole shift
    generate
        if (HAS_REM) begin : g_rem
            assign o_rem = {1'b0, cnt[LB-1:0]};
        end else begin : g_norem
            assign o_rem = '0;
        end
    endgenerate

    assign cnt_dec     = cnt - B_CNT;
    assign o_rem_valid = (state == COUNT) & first_r & i_right_shift_op & HAS_REM & (o_rem != '0);
    // Underflow into bit SHW marks the final step
    assign o_sh_done   = (state == COUNT) & ~o_rem_valid & cnt_dec[SHW];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            first_r     <= 1'b0;
            o_sh_done_r <= 1'b0;
        end else begin
            o_sh_done_r <= o_sh_done;
            first_r     <= 1'b0;
            if (!i_shift_op && !i_init) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_init && i_shift_op && i_en)
                            state <= FILL;
                    end
                    FILL: begin
                        if (i_cnt_done && i_en) begin
                            state   <= COUNT;
                            cnt     <= {1'b0, dat_nxt[SHW-1:0]};
                            first_r <= 1'b1;
                        end
                    end
                    COUNT: begin
                        if (!o_rem_valid)
                            cnt <= cnt_dec;
                        if (o_sh_done)
                            state <= DONE;
                    end
                    DONE: begin
                        if (!i_shift_op)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serv_shbuf.sv
// Directed bench for serv_shbuf (W=32, four bits per cycle) with a scoreboard of
// expected shift completion cycles and final data words.
module tb_serv_shbuf;

    localparam int W = 32;
    localparam int B = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_en = 1'b0, i_init = 1'b0, i_cnt_done = 1'b0;
    logic [1:0]    i_lsb = 2'd0;
    logic          i_byte_valid = 1'b0, i_shift_op = 1'b0, i_right_shift_op = 1'b0;
    logic          i_op_b_sel = 1'b0;
    logic [B-1:0]  i_rs2 = '0, i_imm = '0;
    logic [B-1:0]  o_op_b, o_q;
    logic          o_sh_done, o_sh_done_r, o_rem_valid;
    logic [2:0]    o_rem;
    logic [W-1:0]  o_dat;
    logic          i_load = 1'b0;
    logic [W-1:0]  i_dat = '0;

    int n_assert = 0;
    int n_fail   = 0;
    int          exp_done_q[$];
    logic [31:0] exp_dat_q[$];

    serv_shbuf #(.W(W), .BITS_PER_CYCLE(B)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_init(i_init),
        .i_cnt_done(i_cnt_done), .i_lsb(i_lsb), .i_byte_valid(i_byte_valid),
        .i_shift_op(i_shift_op), .i_right_shift_op(i_right_shift_op),
        .i_op_b_sel(i_op_b_sel), .i_rs2(i_rs2), .i_imm(i_imm),
        .o_op_b(o_op_b), .o_q(o_q), .o_sh_done(o_sh_done), .o_sh_done_r(o_sh_done_r),
        .o_rem(o_rem), .o_rem_valid(o_rem_valid), .o_dat(o_dat),
        .i_load(i_load), .i_dat(i_dat)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // mode 0: run to completion, 1: abort in first COUNT cycle, 2: reset while in DONE
    task automatic run_shift(input logic [31:0] operand, input bit right, input bit use_rs2,
                             input int mode, input bit do_load, input logic [31:0] mid_dat);
        int shamt, rem, rv, k, rvcnt, exp_done;
        logic [31:0] exp_dat;
        shamt = int'(operand[4:0]);
        rem   = shamt % B;
        rv    = (right && rem != 0) ? 1 : 0;
        if (mode != 1) begin
            exp_done_q.push_back(rv + shamt / B + 1);
            exp_dat_q.push_back(do_load ? mid_dat : operand);
        end
        i_right_shift_op = right;
        i_op_b_sel       = use_rs2;
        i_shift_op       = 1'b1;
        for (int s = 0; s < W / B; s++) begin
            i_init       = 1'b1;
            i_en         = 1'b1;
            i_byte_valid = (s == 0);
            i_cnt_done   = (s == W / B - 1);
            i_rs2 = use_rs2 ? operand[B*s +: B] : ~operand[B*s +: B];
            i_imm = use_rs2 ? ~operand[B*s +: B] : operand[B*s +: B];
            step();
        end
        i_init = 1'b0; i_en = 1'b0; i_byte_valid = 1'b0; i_cnt_done = 1'b0;
        chk("rem_first", o_rem, rem);
        chk("rem_valid_first", o_rem_valid, rv);
        if (mode == 1) begin
            i_shift_op = 1'b0;
            step();
            chk("abort_rem_cleared", o_rem, 0);
            chk("abort_no_done", o_sh_done, 0);
            chk("abort_rem_valid", o_rem_valid, 0);
            return;
        end
        k = 1;
        rvcnt = 0;
        for (int g = 0; g < 40; g++) begin
            if (o_rem_valid) rvcnt++;
            if (o_sh_done) break;
            i_load = do_load && (k == 1);
            i_dat  = mid_dat;
            step();
            i_load = 1'b0;
            k++;
        end
        exp_done = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : -1;
        exp_dat  = (exp_dat_q.size() > 0) ? exp_dat_q.pop_front() : 'x;
        chk("done_cycle", k, exp_done);
        chk("rem_valid_cycles", rvcnt, rv);
        chk("rem_held", o_rem, rem);
        step();
        chk("sh_done_r", o_sh_done_r, 1);
        chk("done_state_no_done", o_sh_done, 0);
        chk("dat_after_shift", o_dat, exp_dat);
        if (mode == 2) begin
            #2 i_rst = 1'b1;
            #1;
            chk("rst_sh_done_r", o_sh_done_r, 0);
            chk("rst_dat", o_dat, 0);
            chk("rst_rem", o_rem, 0);
            chk("rst_q", o_q, 0);
            i_shift_op = 1'b0;
            step();
            i_rst = 1'b0;
            step();
            return;
        end
        i_shift_op = 1'b0;
        step();
        chk("idle_sh_done_r", o_sh_done_r, 0);
    endtask

    initial begin
        #1;
        chk("reset_dat", o_dat, 0);
        chk("reset_q", o_q, 0);
        chk("reset_sh_done_r", o_sh_done_r, 0);
        chk("reset_rem_valid", o_rem_valid, 0);
        chk("reset_sh_done", o_sh_done, 0);
        step();
        i_rst = 1'b0;
        step();

        // Operand B mux
        i_rs2 = 4'hA; i_imm = 4'h5; i_op_b_sel = 1'b1; #1;
        chk("op_b_rs2", o_op_b, 4'hA);
        i_op_b_sel = 1'b0; #1;
        chk("op_b_imm", o_op_b, 4'h5);

        // Bus load and byte-lane selection
        i_dat = 32'hA1B2C3D4; i_load = 1'b1; i_en = 1'b1; i_byte_valid = 1'b1;
        step();
        i_load = 1'b0; i_en = 1'b0; i_byte_valid = 1'b0;
        chk("load_dat", o_dat, 32'hA1B2C3D4);
        for (int l = 0; l < 4; l++) begin
            i_lsb = 2'(l); #1;
            chk("q_lane", o_q, 4 - l);
        end
        i_lsb = 2'd0;

        // Serial shift gating outside a shift operation
        i_op_b_sel = 1'b1; i_rs2 = 4'hF;
        i_en = 1'b1; i_byte_valid = 1'b0; step();
        chk("no_shift_invalid", o_dat, 32'hA1B2C3D4);
        i_en = 1'b0; i_byte_valid = 1'b1; step();
        chk("no_shift_disabled", o_dat, 32'hA1B2C3D4);
        i_en = 1'b1; i_byte_valid = 1'b1; step();
        chk("shift_in", o_dat, 32'hFA1B2C3D);
        chk("shift_in_q", o_q, 4'hD);
        i_en = 1'b0; i_byte_valid = 1'b0;

        run_shift(32'h12345667, 1'b1, 1'b1, 0, 1'b0, '0);          // SRL 7: remainder 3
        run_shift(32'hDEADBEE0, 1'b0, 1'b0, 0, 1'b0, '0);          // shamt 0 via imm
        run_shift(32'hCAFEF00F, 1'b0, 1'b1, 0, 1'b1, 32'h0BADF00D); // load during COUNT
        run_shift(32'h8765431F, 1'b1, 1'b1, 0, 1'b0, '0);          // shamt W-1
        run_shift(32'h00000014, 1'b1, 1'b0, 0, 1'b0, '0);          // right, remainder 0
        run_shift(32'h00000006, 1'b1, 1'b1, 1, 1'b0, '0);          // aborted
        run_shift(32'h00000005, 1'b0, 1'b1, 2, 1'b0, '0);          // reset in DONE
        run_shift(32'h0000000B, 1'b1, 1'b1, 0, 1'b0, '0);          // recovery after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
